// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause bit positions, ExcCodes,
// the accept-event encoding and a Cause word packer.
package cp0_pkg;

  localparam logic [4:0] BADVADDR = 5'd8;
  localparam logic [4:0] COUNT    = 5'd9;
  localparam logic [4:0] COMPARE  = 5'd11;
  localparam logic [4:0] STATUS   = 5'd12;
  localparam logic [4:0] CAUSE    = 5'd13;
  localparam logic [4:0] EPC      = 5'd14;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int IM_BASE  = 8;
  localparam int CAUSE_TI = 30;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Exactly one of these is applied at a falling edge, highest priority first.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_EXC,
    EV_INT,
    EV_ERET,
    EV_MTC0
  } cp0_event_e;

  function automatic logic [31:0] pack_cause(input logic [4:0] exc_code,
                                             input logic [7:0] ip,
                                             input logic       ti);
    logic [31:0] word;
    word           = '0;
    word[6:2]      = exc_code;
    word[15:8]     = ip;
    word[CAUSE_TI] = ti;
    return word;
  endfunction

endpackage

// File: rtl/cp0_intc_if.sv
// CPU <-> CP0 connection: instruction decode strobes, exception info, irq lines and results.
interface cp0_intc_if #(
  parameter int NUM_IRQ = 6
);
  logic               mfc0;
  logic               mtc0;
  logic               eret;
  logic               exception;
  logic [4:0]         cause;
  logic               commit;
  logic [31:0]        pc;
  logic [31:0]        badvaddr;
  logic [4:0]         addr;
  logic [31:0]        data;
  logic [NUM_IRQ-1:0] irq;
  logic [31:0]        rdata;
  logic [31:0]        status;
  logic [31:0]        exc_addr;
  logic               int_req;
  logic               exc_taken;

  modport master (
    output mfc0, mtc0, eret, exception, cause, commit, pc, badvaddr, addr, data, irq,
    input  rdata, status, exc_addr, int_req, exc_taken
  );

  modport slave (
    input  mfc0, mtc0, eret, exception, cause, commit, pc, badvaddr, addr, data, irq,
    output rdata, status, exc_addr, int_req, exc_taken
  );
endinterface

// File: rtl/cp0_intc_irq_sync.sv
// Two-flop synchroniser for the asynchronous interrupt lines, clocked on the CPU's
// falling edge so IP changes line up with all other CP0 state updates.
module irq_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq,
  output logic [WIDTH-1:0] ip
);

  logic [WIDTH-1:0] meta;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      ip   <= '0;
    end else begin
      meta <= irq;
      ip   <= meta;
    end
  end

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor 0 with Status/Cause/EPC/BadVAddr and masked, EXL-guarded interrupts.
// Optional Count/Compare timer is compiled in with CP0_TIMER_EN; its flag drives the top IP line.
module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h00400000,
  parameter logic [31:0] STATUS_RST = 32'h0000000f
) (
  input logic       clk,
  input logic       rst,
  cp0_intc_if.slave bus
);

  logic [31:0]        status_q;
  logic [31:0]        epc_q;
  logic [31:0]        badvaddr_q;
  logic [4:0]         exc_code_q;
  logic [NUM_IRQ-1:0] ip_sync;
  logic [NUM_IRQ-1:0] ip;
  logic [NUM_IRQ-1:0] im;
  logic               ti;
  logic               int_req;
  logic [31:0]        cause_word;
  logic [31:0]        rdata;
  cp0_event_e         ev;

  irq_sync #(
    .WIDTH (NUM_IRQ)
  ) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .irq (bus.irq),
    .ip  (ip_sync)
  );

`ifdef CP0_TIMER_EN
  localparam logic [NUM_IRQ-1:0] TI_LINE = NUM_IRQ'(1) << (NUM_IRQ - 1);

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = (ev == EV_MTC0) && (bus.addr == COUNT);
  assign wr_compare = (ev == EV_MTC0) && (bus.addr == COMPARE);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= 32'hffffffff;
      ti_q      <= 1'b0;
    end else begin
      count_q <= wr_count ? bus.data : count_q + 32'd1;
      if (wr_compare) begin
        compare_q <= bus.data;
      end
      // A Compare write acknowledges the timer even if it coincides with a match.
      if (wr_compare) begin
        ti_q <= 1'b0;
      end else if (count_q == compare_q) begin
        ti_q <= 1'b1;
      end
    end
  end

  assign ti = ti_q;
  assign ip = ip_sync | (ti_q ? TI_LINE : '0);
`else
  assign ti = 1'b0;
  assign ip = ip_sync;
`endif

  assign im      = status_q[IM_BASE +: NUM_IRQ];
  assign int_req = status_q[SR_IE] & ~status_q[SR_EXL] & (|(ip & im));

  always_comb begin
    ev = EV_NONE;
    if (bus.exception) begin
      ev = EV_EXC;
    end else if (int_req && bus.commit) begin
      ev = EV_INT;
    end else if (bus.eret) begin
      ev = EV_ERET;
    end else if (bus.mtc0) begin
      ev = EV_MTC0;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      epc_q      <= '0;
      badvaddr_q <= '0;
      exc_code_q <= '0;
    end else begin
      case (ev)
        EV_EXC: begin
          epc_q            <= bus.pc;
          exc_code_q       <= bus.cause;
          badvaddr_q       <= bus.badvaddr;
          status_q[SR_EXL] <= 1'b1;
        end
        EV_INT: begin
          epc_q            <= bus.pc;
          exc_code_q       <= EXC_INT;
          status_q[SR_EXL] <= 1'b1;
        end
        EV_ERET: begin
          status_q[SR_EXL] <= 1'b0;
        end
        EV_MTC0: begin
          // Cause is read-only; Count/Compare writes are handled by the timer block.
          case (bus.addr)
            BADVADDR: badvaddr_q <= bus.data;
            STATUS:   status_q   <= bus.data;
            EPC:      epc_q      <= bus.data;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign cause_word = pack_cause(exc_code_q, 8'(ip), ti);

  always_comb begin
    rdata = '0;
    case (bus.addr)
      BADVADDR: rdata = badvaddr_q;
      STATUS:   rdata = status_q;
      CAUSE:    rdata = cause_word;
      EPC:      rdata = epc_q;
`ifdef CP0_TIMER_EN
      COUNT:    rdata = count_q;
      COMPARE:  rdata = compare_q;
`endif
      default:  rdata = '0;
    endcase
    if (!bus.mfc0) begin
      rdata = '0;
    end
  end

  assign bus.rdata     = rdata;
  assign bus.status    = status_q;
  assign bus.int_req   = int_req;
  assign bus.exc_taken = bus.exception | (int_req & bus.commit);
  assign bus.exc_addr  = bus.eret ? epc_q : EXC_VECTOR;

endmodule

// File: tb/tb_cp0_intc.sv
// Vector/scoreboard bench for cp0_intc; define CP0_TIMER_EN to also exercise the timer.
module tb_cp0_intc;
  import cp0_pkg::*;

  localparam logic [31:0] VEC = 32'h00400000;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic        T   = 1'b1;
  localparam logic        F   = 1'b0;
  localparam logic [4:0]  C0  = 5'd0;
  localparam logic [4:0]  NA  = 5'd3;
  localparam logic [5:0]  I0  = 6'd0;
  localparam logic [5:0]  I1  = 6'd1;

  typedef struct {
    logic        mfc0, mtc0, eret, exception, commit;
    logic [4:0]  cause, addr;
    logic [31:0] pc, badvaddr, data;
    logic [5:0]  irq;
    logic [31:0] e_rdata, e_status, e_exc_addr;
    logic        e_int_req, e_exc_taken;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rdata, status, exc_addr;
    logic        int_req, exc_taken;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t tbl[$];
  exp_t sb[$];

  cp0_intc_if #(.NUM_IRQ(6)) bus ();

  cp0_intc #(
    .NUM_IRQ    (6),
    .EXC_VECTOR (32'h00400000),
    .STATUS_RST (32'h0000000f)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic mf, mt, er, ex, input logic [4:0] cs, input logic cm,
                              input logic [31:0] pc, bva, input logic [4:0] ad,
                              input logic [31:0] dt, input logic [5:0] iq,
                              input logic [31:0] rd, st, ea, input logic ir, et);
    vec_t v;
    v.mfc0 = mf; v.mtc0 = mt; v.eret = er; v.exception = ex; v.cause = cs; v.commit = cm;
    v.pc = pc; v.badvaddr = bva; v.addr = ad; v.data = dt; v.irq = iq;
    v.e_rdata = rd; v.e_status = st; v.e_exc_addr = ea; v.e_int_req = ir; v.e_exc_taken = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.mfc0 = 1'b0; bus.mtc0 = 1'b0; bus.eret = 1'b0; bus.exception = 1'b0;
    bus.cause = '0; bus.commit = 1'b0; bus.pc = '0; bus.badvaddr = '0;
    bus.addr = '0; bus.data = '0; bus.irq = '0;
  endtask

  // Drive one cycle's inputs after the rising edge, check combinational outputs
  // before the falling (state-update) edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(posedge clk);
    #1;
    bus.mfc0 = v.mfc0; bus.mtc0 = v.mtc0; bus.eret = v.eret; bus.exception = v.exception;
    bus.cause = v.cause; bus.commit = v.commit; bus.pc = v.pc; bus.badvaddr = v.badvaddr;
    bus.addr = v.addr; bus.data = v.data; bus.irq = v.irq;
    e.idx = idx; e.rdata = v.e_rdata; e.status = v.e_status; e.exc_addr = v.e_exc_addr;
    e.int_req = v.e_int_req; e.exc_taken = v.e_exc_taken;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    chk($sformatf("v%0d.rdata", e.idx),     bus.rdata,           e.rdata);
    chk($sformatf("v%0d.status", e.idx),    bus.status,          e.status);
    chk($sformatf("v%0d.exc_addr", e.idx),  bus.exc_addr,        e.exc_addr);
    chk($sformatf("v%0d.int_req", e.idx),   32'(bus.int_req),    32'(e.int_req));
    chk($sformatf("v%0d.exc_taken", e.idx), 32'(bus.exc_taken),  32'(e.exc_taken));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive_idle();

    // Reads and Status write after reset
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,STATUS,Z,I0, 32'hf,32'hf,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, Z,32'hf,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,EPC,Z,I0, Z,32'hf,VEC,F,F));
    tbl.push_back(mk(F,F,F,F,C0,F,Z,Z,STATUS,Z,I0, Z,32'hf,VEC,F,F));
    tbl.push_back(mk(F,T,F,F,C0,F,Z,Z,STATUS,32'h101,I0, Z,32'hf,VEC,F,F));
    // irq[0] through the synchroniser, then taken at commit
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,STATUS,Z,I1, 32'h101,32'h101,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I1, Z,32'h101,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I1, 32'h100,32'h101,VEC,T,F));
    tbl.push_back(mk(T,F,F,F,C0,T,32'h00400200,Z,STATUS,Z,I1, 32'h101,32'h101,VEC,T,T));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,EPC,Z,I1, 32'h00400200,32'h103,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,T,32'h00400204,Z,CAUSE,Z,I1, 32'h100,32'h103,VEC,F,F));
    tbl.push_back(mk(F,F,T,F,C0,F,Z,Z,C0,Z,I1, Z,32'h103,32'h00400200,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,STATUS,Z,I1, 32'h101,32'h101,VEC,T,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, 32'h100,32'h101,VEC,T,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, 32'h100,32'h101,VEC,T,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, Z,32'h101,VEC,F,F));
    // Synchronous exception and eret
    tbl.push_back(mk(F,F,F,T,EXC_SYS,F,32'h00400100,32'h12345678,C0,Z,I0, Z,32'h101,VEC,F,T));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,EPC,Z,I0, 32'h00400100,32'h103,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, 32'h20,32'h103,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,BADVADDR,Z,I0, 32'h12345678,32'h103,VEC,F,F));
    tbl.push_back(mk(T,F,T,F,C0,F,Z,Z,STATUS,Z,I0, 32'h103,32'h103,32'h00400100,F,F));
    // Exception, interrupt and mtc0 in one cycle
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,STATUS,Z,I1, 32'h101,32'h101,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I1, 32'h20,32'h101,VEC,F,F));
    tbl.push_back(mk(F,T,F,T,EXC_OV,T,32'h00400300,32'hcafef00d,STATUS,32'h0000ff00,I1, Z,32'h101,VEC,T,T));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I1, 32'h130,32'h103,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,EPC,Z,I1, 32'h00400300,32'h103,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,BADVADDR,Z,I1, 32'hcafef00d,32'h103,VEC,F,F));
    // Ignored/discarded writes, EPC write, eret re-enables interrupts
    tbl.push_back(mk(F,T,F,F,C0,F,Z,Z,CAUSE,32'hffffffff,I1, Z,32'h103,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I1, 32'h130,32'h103,VEC,F,F));
    tbl.push_back(mk(F,T,F,F,C0,F,Z,Z,NA,32'hffffffff,I1, Z,32'h103,VEC,F,F));
    tbl.push_back(mk(F,T,F,F,C0,F,Z,Z,EPC,32'h00400444,I1, Z,32'h103,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,EPC,Z,I1, 32'h00400444,32'h103,VEC,F,F));
    tbl.push_back(mk(F,F,T,F,C0,F,Z,Z,C0,Z,I1, Z,32'h103,32'h00400444,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,STATUS,Z,I1, 32'h101,32'h101,VEC,T,F));
    tbl.push_back(mk(F,T,F,F,C0,F,Z,Z,STATUS,Z,I1, Z,32'h101,VEC,T,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,STATUS,Z,I0, Z,Z,VEC,F,F));
    tbl.push_back(mk(F,T,T,F,C0,F,Z,Z,STATUS,32'habcd,I0, Z,Z,32'h00400444,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,STATUS,Z,I0, Z,Z,VEC,F,F));
    tbl.push_back(mk(F,T,F,F,C0,F,Z,Z,STATUS,32'ha5a50000,I0, Z,Z,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,STATUS,Z,I0, 32'ha5a50000,32'ha5a50000,VEC,F,F));
    tbl.push_back(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, 32'h30,32'ha5a50000,VEC,F,F));

    // Outputs while reset is held
    #12;
    chk("rst.status",    bus.status,          32'hf);
    chk("rst.rdata",     bus.rdata,           Z);
    chk("rst.exc_addr",  bus.exc_addr,        VEC);
    chk("rst.int_req",   32'(bus.int_req),    Z);
    chk("rst.exc_taken", 32'(bus.exc_taken),  Z);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

`ifndef CP0_TIMER_EN
    apply(mk(F,T,F,F,C0,F,Z,Z,COMPARE,32'h7,I0, Z,32'ha5a50000,VEC,F,F), 100);
    apply(mk(F,T,F,F,C0,F,Z,Z,COUNT,32'h7,I0, Z,32'ha5a50000,VEC,F,F), 101);
    apply(mk(T,F,F,F,C0,F,Z,Z,COUNT,Z,I0, Z,32'ha5a50000,VEC,F,F), 102);
    apply(mk(T,F,F,F,C0,F,Z,Z,COMPARE,Z,I0, Z,32'ha5a50000,VEC,F,F), 103);
    apply(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, 32'h30,32'ha5a50000,VEC,F,F), 104);
`endif

    // Reset in the middle of a handler
    apply(mk(F,F,F,T,EXC_BP,F,32'h00400600,Z,C0,Z,I0, Z,32'ha5a50000,VEC,F,T), 110);
    apply(mk(T,F,F,F,C0,F,Z,Z,STATUS,Z,I0, 32'ha5a50002,32'ha5a50002,VEC,F,F), 111);
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1'b1;
    bus.mfc0 = 1'b1;
    bus.addr = EPC;
    #1;
    chk("midrst.status", bus.status, 32'hf);
    chk("midrst.epc",    bus.rdata,  Z);
    bus.addr = CAUSE;
    #1;
    chk("midrst.cause",  bus.rdata,  Z);
    @(posedge clk);
    #1 rst = 1'b0;
    drive_idle();
    apply(mk(T,F,F,F,C0,F,Z,Z,STATUS,Z,I0, 32'hf,32'hf,VEC,F,F), 112);

`ifdef CP0_TIMER_EN
    apply(mk(F,T,F,F,C0,F,Z,Z,STATUS,32'h2001,I0, Z,32'hf,VEC,F,F), 200);
    apply(mk(F,T,F,F,C0,F,Z,Z,COMPARE,32'h5,I0, Z,32'h2001,VEC,F,F), 201);
    apply(mk(F,T,F,F,C0,F,Z,Z,COUNT,Z,I0, Z,32'h2001,VEC,F,F), 202);
    for (int k = 0; k < 6; k++) begin
      apply(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, Z,32'h2001,VEC,F,F), 210 + k);
    end
    apply(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, 32'h40002000,32'h2001,VEC,T,F), 220);
    apply(mk(F,F,F,F,C0,T,32'h00400500,Z,C0,Z,I0, Z,32'h2001,VEC,T,T), 221);
    apply(mk(T,F,F,F,C0,F,Z,Z,EPC,Z,I0, 32'h00400500,32'h2003,VEC,F,F), 222);
    apply(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, 32'h40002000,32'h2003,VEC,F,F), 223);
    apply(mk(F,T,F,F,C0,F,Z,Z,COMPARE,32'd100,I0, Z,32'h2003,VEC,F,F), 224);
    apply(mk(T,F,F,F,C0,F,Z,Z,CAUSE,Z,I0, Z,32'h2003,VEC,F,F), 225);
    apply(mk(T,F,F,F,C0,F,Z,Z,COMPARE,Z,I0, 32'd100,32'h2003,VEC,F,F), 226);
    apply(mk(F,T,F,F,C0,F,Z,Z,COUNT,32'h1000,I0, Z,32'h2003,VEC,F,F), 227);
    apply(mk(T,F,F,F,C0,F,Z,Z,COUNT,Z,I0, 32'h1000,32'h2003,VEC,F,F), 228);
    apply(mk(T,F,F,F,C0,F,Z,Z,COUNT,Z,I0, 32'h1001,32'h2003,VEC,F,F), 229);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
